// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: FETCH, DECODE, EXEC, MEM and WB.
// Holds the instruction register and the sticky illegal-opcode flag.
module multicycle_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  branch_taken,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [2:0]            state,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  pc_write,
  output logic [1:0]            pc_sel,
  output logic                  illegal_instr,
  output logic                  retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h13);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic                  illegal_q;

  logic [6:0] op;
  logic is_load, is_store, is_branch, is_jal, is_jalr, legal;

  assign op        = ir_q[6:0];
  assign is_load   = (op == 7'b0000011);
  assign is_store  = (op == 7'b0100011);
  assign is_branch = (op == 7'b1100011);
  assign is_jal    = (op == 7'b1101111);
  assign is_jalr   = (op == 7'b1100111);
  assign legal     = is_load | is_store | is_branch
                   | is_jal | is_jalr
                   | (op == 7'b0110011)
                   | (op == 7'b0010011)
                   | (op == 7'b0110111)
                   | (op == 7'b0010111);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= NOP;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_write)
        ir_q <= mem_rdata;
      if (state_q == DECODE && !legal)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'd0;
    retired   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          pc_write = 1'b1;
          retired  = 1'b1;
          state_d  = FETCH;
        end
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? 2'd1 : 2'd0;
          retired  = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_write = 1'b1;
            retired  = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retired   = 1'b1;
        state_d   = FETCH;
        unique case (1'b1)
          is_jal:  pc_sel = 2'd1;
          is_jalr: pc_sel = 2'd2;
          default: pc_sel = 2'd0;
        endcase
      end
      default: state_d = FETCH;
    endcase
    // Reset silences every strobe, even mid-access.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 2'd0;
      retired   = 1'b0;
    end
  end

  assign ir            = ir_q;
  assign state         = state_q;
  assign illegal_instr = illegal_q;

endmodule
